// File: rtl/dmem_responder.sv
// Data-memory responder: valid/ready request, WAIT_STATES wait cycles,
// one-cycle response. Optional DMEM_ERR_STICKY_EN adds err_sticky output.
// Ports: clk, rst (async low), req_valid/req_ready, mem_write, mem_read,
// addr, wdata in; rsp_valid, rdata, rsp_err out.
module dmem_responder #(
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  mem_write,
  input  logic [2:0]  mem_read,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        rsp_valid,
  output logic [31:0] rdata,
  output logic        rsp_err
`ifdef DMEM_ERR_STICKY_EN
  ,
  output logic        err_sticky
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam logic [32:0] LIMIT = 33'(DEPTH) * 33'd4;
  localparam logic [CW-1:0] CNT_INIT =
    CW'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]  wr_q, wr_d;
  logic [2:0]  rd_q, rd_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        req_ready_q, req_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rdata_q, rdata_d;
  logic        rsp_err_q, rsp_err_d;

  logic [31:0] mem_q [DEPTH];

  // Decode the live request in IDLE so a zero-wait response
  // can be formed on the accepting edge; otherwise the latched one.
  logic        in_idle;
  logic [2:0]  s_wr, s_rd;
  logic [31:0] s_addr, s_wdata;
  logic [AW-1:0] idx;
  logic [31:0] word, sh_word;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic        is_half, is_word, misal, oor, illegal, both, err;
  logic [31:0] load_v, rdata_nxt;
  logic [3:0]  be;
  logic [31:0] wd;
  logic        we;

  assign in_idle = (state_q == S_IDLE);
  assign s_wr    = in_idle ? mem_write : wr_q;
  assign s_rd    = in_idle ? mem_read  : rd_q;
  assign s_addr  = in_idle ? addr      : addr_q;
  assign s_wdata = in_idle ? wdata     : wdata_q;

  assign idx     = s_addr[AW+1:2];
  assign word    = mem_q[idx];
  assign sh_word = word >> {s_addr[1:0], 3'b000};
  assign byte_v  = sh_word[7:0];
  assign half_v  = s_addr[1] ? word[31:16] : word[15:0];

  assign illegal = (s_wr > 3'd3) || (s_rd > 3'd5);
  assign both    = (s_wr != 3'd0) && (s_rd != 3'd0);
  assign is_half = (s_wr == 3'd2) || (s_rd == 3'd2) || (s_rd == 3'd5);
  assign is_word = (s_wr == 3'd3) || (s_rd == 3'd3);
  assign misal   = (is_half && s_addr[0]) ||
                   (is_word && (s_addr[1:0] != 2'b00));
  assign oor     = ({1'b0, s_addr} >= LIMIT);
  assign err     = illegal || both || misal || oor;

  always_comb begin
    load_v = 32'd0;
    case (s_rd)
      3'd1:    load_v = {{24{byte_v[7]}}, byte_v};
      3'd2:    load_v = {{16{half_v[15]}}, half_v};
      3'd3:    load_v = word;
      3'd4:    load_v = {24'd0, byte_v};
      3'd5:    load_v = {16'd0, half_v};
      default: load_v = 32'd0;
    endcase
  end

  assign rdata_nxt = err ? 32'd0 : load_v;

  always_comb begin
    be = 4'b0000;
    wd = s_wdata;
    case (s_wr)
      3'd1: begin
        be = 4'b0001 << s_addr[1:0];
        wd = {4{s_wdata[7:0]}};
      end
      3'd2: begin
        be = s_addr[1] ? 4'b1100 : 4'b0011;
        wd = {2{s_wdata[15:0]}};
      end
      3'd3:    be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  assign we = (state_q == S_RESP) && !err;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wr_d        = wr_q;
    rd_d        = rd_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = 1'b0;
    rdata_d     = rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          wr_d        = mem_write;
          rd_d        = mem_read;
          addr_d      = addr;
          wdata_d     = wdata;
          req_ready_d = 1'b0;
          if (WAIT_STATES == 0) begin
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            rdata_d     = rdata_nxt;
            rsp_err_d   = err;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rdata_d     = rdata_nxt;
          rsp_err_d   = err;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_RESP: begin
        state_d     = S_IDLE;
        req_ready_d = 1'b1;
      end
      default: begin
        state_d     = S_IDLE;
        req_ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      wr_q        <= 3'd0;
      rd_q        <= 3'd0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rdata_q     <= 32'd0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Array is not reset; store commits on the edge leaving RESP.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we && be[i]) mem_q[idx][8*i +: 8] <= wd[8*i +: 8];
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rdata     = rdata_q;
  assign rsp_err   = rsp_err_q;

`ifdef DMEM_ERR_STICKY_EN
  logic sticky_q, sticky_d;

  assign sticky_d = sticky_q || ((state_q == S_RESP) && rsp_err_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sticky_q <= 1'b0;
    else      sticky_q <= sticky_d;
  end

  assign err_sticky = sticky_q;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Directed testbench for dmem_responder (WAIT_STATES=2 and 0 instances).
// Prints one summary line with error and check counts.
module tb_dmem_responder;

  localparam logic [2:0] NONE = 3'b000;
  localparam logic [2:0] SB   = 3'b001;
  localparam logic [2:0] SH   = 3'b010;
  localparam logic [2:0] SW   = 3'b011;
  localparam logic [2:0] LB   = 3'b001;
  localparam logic [2:0] LH   = 3'b010;
  localparam logic [2:0] LW   = 3'b011;
  localparam logic [2:0] LBU  = 3'b100;
  localparam logic [2:0] LHU  = 3'b101;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  mem_write = '0;
  logic [2:0]  mem_read = '0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        rsp_valid;
  logic [31:0] rdata;
  logic        rsp_err;

  logic        b_valid = 1'b0;
  logic        b_ready;
  logic [2:0]  b_write = '0;
  logic [2:0]  b_read = '0;
  logic [31:0] b_addr = '0;
  logic [31:0] b_wdata = '0;
  logic        b_rsp_valid;
  logic [31:0] b_rdata;
  logic        b_rsp_err;

`ifdef DMEM_ERR_STICKY_EN
  logic        err_sticky;
  logic        b_err_sticky;
`endif

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(1024), .WAIT_STATES(2)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .mem_write (mem_write),
    .mem_read  (mem_read),
    .addr      (addr),
    .wdata     (wdata),
    .rsp_valid (rsp_valid),
    .rdata     (rdata),
    .rsp_err   (rsp_err)
`ifdef DMEM_ERR_STICKY_EN
    ,
    .err_sticky(err_sticky)
`endif
  );

  dmem_responder #(.DEPTH(1024), .WAIT_STATES(0)) u_dut0 (
    .clk       (clk),
    .rst       (rst),
    .req_valid (b_valid),
    .req_ready (b_ready),
    .mem_write (b_write),
    .mem_read  (b_read),
    .addr      (b_addr),
    .wdata     (b_wdata),
    .rsp_valid (b_rsp_valid),
    .rdata     (b_rdata),
    .rsp_err   (b_rsp_err)
`ifdef DMEM_ERR_STICKY_EN
    ,
    .err_sticky(b_err_sticky)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One request on the WAIT_STATES=2 instance; checks timing and
  // hands back the response payload.
  task automatic xact(input logic [2:0] w, input logic [2:0] r,
                      input logic [31:0] a, input logic [31:0] d,
                      output logic [31:0] rd, output logic er);
    int   lat;
    logic rdy_low;
    @(negedge clk);
    req_valid = 1'b1;
    mem_write = w;
    mem_read  = r;
    addr      = a;
    wdata     = d;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    mem_write = SW;
    mem_read  = NONE;
    addr      = 32'h44;
    wdata     = 32'h5A5A5A5A;
    lat     = 1;
    rdy_low = 1'b1;
    while (!rsp_valid && lat < 20) begin
      if (req_ready) rdy_low = 1'b0;
      @(negedge clk);
      lat++;
    end
    if (req_ready) rdy_low = 1'b0;
    chk("latency", lat, 3);
    chk("ready_low", {31'd0, rdy_low}, 1);
    rd = rdata;
    er = rsp_err;
    @(negedge clk);
    chk("ready_back", {31'd0, req_ready}, 1);
    chk("valid_drop", {31'd0, rsp_valid}, 0);
    chk("rdata_hold", rdata, rd);
  endtask

  task automatic ld(input string tag, input logic [2:0] r,
                    input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] rd;
    logic        er;
    xact(NONE, r, a, 32'd0, rd, er);
    chk(tag, rd, exp);
    chk({tag, "_err"}, {31'd0, er}, 0);
  endtask

  task automatic st(input string tag, input logic [2:0] w,
                    input logic [31:0] a, input logic [31:0] d);
    logic [31:0] rd;
    logic        er;
    xact(w, NONE, a, d, rd, er);
    chk({tag, "_rdata"}, rd, 0);
    chk({tag, "_err"}, {31'd0, er}, 0);
  endtask

  task automatic bad(input string tag, input logic [2:0] w,
                     input logic [2:0] r, input logic [31:0] a);
    logic [31:0] rd;
    logic        er;
    xact(w, r, a, 32'h12345678, rd, er);
    chk({tag, "_rdata"}, rd, 0);
    chk({tag, "_err"}, {31'd0, er}, 1);
  endtask

  initial begin
    logic seen;
    logic [31:0] rd;
    logic        er;

    repeat (2) @(negedge clk);
    chk("rst_ready", {31'd0, req_ready}, 1);
    chk("rst_valid", {31'd0, rsp_valid}, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_err", {31'd0, rsp_err}, 0);
`ifdef DMEM_ERR_STICKY_EN
    chk("rst_sticky", {31'd0, err_sticky}, 0);
`endif
    rst = 1'b1;

    st("sw10", SW, 32'h10, 32'hDEADBEEF);
    ld("lw10", LW, 32'h10, 32'hDEADBEEF);

    st("sw20", SW, 32'h20, 32'h11223344);
    st("sb21", SB, 32'h21, 32'h000000F0);
    ld("lb21", LB, 32'h21, 32'hFFFFFFF0);
    ld("lbu21", LBU, 32'h21, 32'h000000F0);
    ld("lh22", LH, 32'h22, 32'h00001122);
    ld("lhu22", LHU, 32'h22, 32'h00001122);
    ld("lh20", LH, 32'h20, 32'hFFFFF044);
    ld("lw20", LW, 32'h20, 32'h1122F044);

    // No-op request still gets a clean response.
    xact(NONE, NONE, 32'h10, 32'hFFFFFFFF, rd, er);
    chk("nop_rdata", rd, 0);
    chk("nop_err", {31'd0, er}, 0);

`ifdef DMEM_ERR_STICKY_EN
    chk("sticky_clear", {31'd0, err_sticky}, 0);
`endif
    bad("lw_mis", NONE, LW, 32'h22);
    bad("sh_mis", SH, NONE, 32'h13);
    bad("lw_oor", NONE, LW, 32'h1000);
    ld("lw10_keep", LW, 32'h10, 32'hDEADBEEF);
    ld("lw20_keep", LW, 32'h20, 32'h1122F044);
`ifdef DMEM_ERR_STICKY_EN
    chk("sticky_set", {31'd0, err_sticky}, 1);
`endif

    st("sw30", SW, 32'h30, 32'hCAFEF00D);
    bad("both", SW, LW, 32'h30);
    bad("rd110", NONE, 3'b110, 32'h30);
    bad("wr111", 3'b111, NONE, 32'h30);
    ld("lw30_keep", LW, 32'h30, 32'hCAFEF00D);

    st("sw40", SW, 32'h40, 32'h0BADF00D);
    ld("lw10_pre", LW, 32'h10, 32'hDEADBEEF);

    // Reset pulse while the store sits in WAIT.
    @(negedge clk);
    req_valid = 1'b1;
    mem_write = SW;
    mem_read  = NONE;
    addr      = 32'h40;
    wdata     = 32'hA5A5A5A5;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    #1 rst = 1'b0;
    #1;
    chk("arst_ready", {31'd0, req_ready}, 1);
    chk("arst_valid", {31'd0, rsp_valid}, 0);
    chk("arst_rdata", rdata, 0);
    chk("arst_err", {31'd0, rsp_err}, 0);
`ifdef DMEM_ERR_STICKY_EN
    chk("arst_sticky", {31'd0, err_sticky}, 0);
`endif
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    rst = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    chk("arst_no_rsp", {31'd0, seen}, 0);
    ld("lw40_keep", LW, 32'h40, 32'h0BADF00D);

    // Zero-wait instance with req_valid held high.
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk("b_ready", {31'd0, b_ready}, (k % 2 == 0) ? 1 : 0);
      chk("b_valid", {31'd0, b_rsp_valid}, (k % 2 == 1) ? 1 : 0);
      if (k % 2 == 1)
        chk("b_err", {31'd0, b_rsp_err}, 0);
      if (k >= 7 && k % 2 == 1)
        chk("b_rdata", b_rdata, 32'hB000 + 32'(k - 7));
      b_valid = 1'b1;
      if (k < 6) begin
        b_write = SW;
        b_read  = NONE;
        if (k % 2 == 0) begin
          b_addr  = 32'h50 + 32'(2 * k);
          b_wdata = 32'hB000 + 32'(k);
        end else begin
          b_addr  = 32'h50 + 32'(2 * (k - 1));
          b_wdata = 32'h0000EEEE;
        end
      end else begin
        b_write = NONE;
        b_read  = LW;
        b_wdata = 32'hFFFFFFFF;
        if (k % 2 == 0) b_addr = 32'h50 + 32'(2 * (k - 6));
        else            b_addr = 32'h60;
      end
    end
    @(negedge clk);
    b_valid = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
